// File: rtl/box_draw_scheduler.sv
// Two-requester box filler: round-robin grant, raster-scan plot stream with screen clipping.
// Outputs are registered, one cycle behind the FSM; a side-N box spans N*N+2 cycles from ack to done.
module box_draw_scheduler #(
  parameter int SIZE_W   = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [7:0]        x0,
  input  logic [7:0]        x1,
  input  logic [6:0]        y0,
  input  logic [6:0]        y1,
  input  logic [SIZE_W-1:0] size0,
  input  logic [SIZE_W-1:0] size1,
  input  logic [2:0]        colour0,
  input  logic [2:0]        colour1,
  output logic [1:0]        ack,
  output logic [1:0]        done,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

  localparam logic [8:0]        XLIM = 9'(SCREEN_W);
  localparam logic [7:0]        YLIM = 8'(SCREEN_H);
  localparam logic [SIZE_W-1:0] ONE  = 1;

  state_t            state;
  logic              ptr;
  logic              gnt;
  logic [7:0]        bx;
  logic [6:0]        by;
  logic [SIZE_W-1:0] bsize;
  logic [2:0]        bcol;
  logic [SIZE_W-1:0] dx;
  logic [SIZE_W-1:0] dy;

  logic              sel;
  logic [SIZE_W-1:0] ssize;
  logic [8:0]        sx;
  logic [7:0]        sy;
  logic              last_col;
  logic              last_row;

  always_comb begin
    sel      = (req == 2'b11) ? ptr : req[1];
    ssize    = sel ? size1 : size0;
    // one extra bit so off-screen coordinates are detected before truncation
    sx       = {1'b0, bx} + 9'(dx);
    sy       = {1'b0, by} + 8'(dy);
    last_col = (dx == bsize - ONE);
    last_row = (dy == bsize - ONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      gnt    <= 1'b0;
      bx     <= '0;
      by     <= '0;
      bsize  <= '0;
      bcol   <= '0;
      dx     <= '0;
      dy     <= '0;
      ack    <= 2'b00;
      done   <= 2'b00;
      plot   <= 1'b0;
      busy   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      ack  <= 2'b00;
      done <= 2'b00;
      plot <= 1'b0;
      case (state)
        IDLE: begin
          busy <= |req;
          if (|req) begin
            gnt   <= sel;
            bx    <= sel ? x1 : x0;
            by    <= sel ? y1 : y0;
            bsize <= ssize;
            bcol  <= sel ? colour1 : colour0;
            dx    <= '0;
            dy    <= '0;
            ack   <= sel ? 2'b10 : 2'b01;
            state <= (ssize != '0) ? DRAW : FINISH;
          end
        end
        DRAW: begin
          busy   <= 1'b1;
          x      <= sx[7:0];
          y      <= sy[6:0];
          colour <= bcol;
          plot   <= (sx < XLIM) && (sy < YLIM);
          if (last_col) begin
            dx <= '0;
            if (last_row) state <= FINISH;
            else          dy    <= dy + ONE;
          end else begin
            dx <= dx + ONE;
          end
        end
        FINISH: begin
          busy  <= 1'b1;
          done  <= gnt ? 2'b10 : 2'b01;
          ptr   <= ~ptr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_box_draw_scheduler.sv
// Bench for box_draw_scheduler: literal vector table, directed corner sequences,
// and randomized traffic checked every cycle against a pixel-index reference model.
module tb_box_draw_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [3:0] size0, size1;
  logic [2:0] colour0, colour1;
  logic [1:0] ack, done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  box_draw_scheduler #(.SIZE_W(4), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .reset(reset), .req(req),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .size0(size0), .size1(size1), .colour0(colour0), .colour1(colour1),
    .ack(ack), .done(done), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
  );

  // reference model: t counts cycles since acceptance (1 = ack cycle,
  // 2..N*N+1 = pixel t-2 in raster order, N*N+2 = done cycle)
  int         m_act, m_t, m_n, m_bx, m_by, m_g, m_ptr;
  logic [2:0] m_col;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;
  logic       m_plot;

  task automatic model_edge();
    int p, xs, ys;
    m_plot = 1'b0;
    if (reset) begin
      m_act = 0; m_t = 0; m_ptr = 0;
      m_x = '0; m_y = '0; m_c = '0;
    end else if (m_act == 0 || m_t == m_n * m_n + 2) begin
      if (req != 2'b00) begin
        m_g   = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
        m_bx  = (m_g == 1) ? int'(x1) : int'(x0);
        m_by  = (m_g == 1) ? int'(y1) : int'(y0);
        m_n   = (m_g == 1) ? int'(size1) : int'(size0);
        m_col = (m_g == 1) ? colour1 : colour0;
        m_t   = 1;
        m_act = 1;
      end else begin
        m_act = 0;
      end
    end else begin
      m_t++;
      if (m_t == m_n * m_n + 2) m_ptr = 1 - m_ptr;
      if (m_t >= 2 && m_t <= m_n * m_n + 1) begin
        p  = m_t - 2;
        xs = m_bx + p % m_n;
        ys = m_by + p / m_n;
        m_x = 8'(xs);
        m_y = 7'(ys);
        m_c = m_col;
        m_plot = (xs < 160) && (ys < 120);
      end
    end
  endtask

  function automatic logic [23:0] exp_vec();
    logic [1:0] a, d;
    a = (m_act != 0 && m_t == 1) ? ((m_g == 1) ? 2'b10 : 2'b01) : 2'b00;
    d = (m_act != 0 && m_t == m_n * m_n + 2) ? ((m_g == 1) ? 2'b10 : 2'b01) : 2'b00;
    return {a, d, m_plot, m_x, m_y, m_c, (m_act != 0)};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {ack, done, plot, x, y, colour, busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h, required %h", name, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", 32'(dut_vec()), 32'(exp_vec()));
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] sz;
    logic [1:0] ack;
    logic [1:0] done;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       busy;
  } vec_t;

  vec_t tv[15];

  initial begin
    logic [1:0] acks[$];
    logic [1:0] dones[$];
    int nplot, ndone10, found;

    // single 3x3 box at (10,20) colour 5, then a zero-size box
    tv[0]  = '{2'b01, 4'd3, 2'b01, 2'b00, 1'b0, 8'd0,  7'd0,  3'd0, 1'b1};
    tv[1]  = '{2'b00, 4'd3, 2'b00, 2'b00, 1'b1, 8'd10, 7'd20, 3'd5, 1'b1};
    tv[2]  = '{2'b00, 4'd3, 2'b00, 2'b00, 1'b1, 8'd11, 7'd20, 3'd5, 1'b1};
    tv[3]  = '{2'b00, 4'd3, 2'b00, 2'b00, 1'b1, 8'd12, 7'd20, 3'd5, 1'b1};
    tv[4]  = '{2'b00, 4'd3, 2'b00, 2'b00, 1'b1, 8'd10, 7'd21, 3'd5, 1'b1};
    tv[5]  = '{2'b00, 4'd3, 2'b00, 2'b00, 1'b1, 8'd11, 7'd21, 3'd5, 1'b1};
    tv[6]  = '{2'b00, 4'd3, 2'b00, 2'b00, 1'b1, 8'd12, 7'd21, 3'd5, 1'b1};
    tv[7]  = '{2'b00, 4'd3, 2'b00, 2'b00, 1'b1, 8'd10, 7'd22, 3'd5, 1'b1};
    tv[8]  = '{2'b00, 4'd3, 2'b00, 2'b00, 1'b1, 8'd11, 7'd22, 3'd5, 1'b1};
    tv[9]  = '{2'b00, 4'd3, 2'b00, 2'b00, 1'b1, 8'd12, 7'd22, 3'd5, 1'b1};
    tv[10] = '{2'b00, 4'd3, 2'b00, 2'b01, 1'b0, 8'd12, 7'd22, 3'd5, 1'b1};
    tv[11] = '{2'b00, 4'd3, 2'b00, 2'b00, 1'b0, 8'd12, 7'd22, 3'd5, 1'b0};
    tv[12] = '{2'b01, 4'd0, 2'b01, 2'b00, 1'b0, 8'd12, 7'd22, 3'd5, 1'b1};
    tv[13] = '{2'b00, 4'd0, 2'b00, 2'b01, 1'b0, 8'd12, 7'd22, 3'd5, 1'b1};
    tv[14] = '{2'b00, 4'd0, 2'b00, 2'b00, 1'b0, 8'd12, 7'd22, 3'd5, 1'b0};

    m_act = 0; m_t = 0; m_n = 0; m_bx = 0; m_by = 0; m_g = 0; m_ptr = 0;
    m_col = '0; m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0;

    reset = 1'b1; req = 2'b00;
    x0 = 8'd10; y0 = 7'd20; size0 = 4'd3; colour0 = 3'd5;
    x1 = 8'd0;  y1 = 7'd0;  size1 = 4'd0; colour1 = 3'd0;
    step();
    step();
    chk("reset_state", 32'(dut_vec()), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      req = tv[i].req;
      size0 = tv[i].sz;
      step();
      chk($sformatf("vec%0d", i), 32'(dut_vec()),
          32'({tv[i].ack, tv[i].done, tv[i].plot, tv[i].x, tv[i].y, tv[i].col, tv[i].busy}));
    end

    // contention: both requesting, grants must alternate starting with 0
    req = 2'b11; x0 = 8'd5; y0 = 7'd5; x1 = 8'd50; y1 = 7'd50;
    size0 = 4'd2; size1 = 4'd2; colour0 = 3'd1; colour1 = 3'd2;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack != 2'b00)  acks.push_back(ack);
      if (done != 2'b00) dones.push_back(done);
    end
    req = 2'b00;
    for (int i = 0; i < 10; i++) step();
    chk("rr_ack_count", 32'(acks.size()), 32'd4);
    chk("rr_done_count", 32'(dones.size()), 32'd3);
    if (acks.size() >= 3)
      chk("rr_ack_order", 32'({acks[0], acks[1], acks[2]}), 32'(6'b01_10_01));
    if (dones.size() >= 3)
      chk("rr_done_order", 32'({dones[0], dones[1], dones[2]}), 32'(6'b01_10_01));

    // clipping at the bottom-right screen corner
    req = 2'b10; x1 = 8'd158; y1 = 7'd118; size1 = 4'd4; colour1 = 3'd7;
    nplot = 0; ndone10 = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      req = 2'b00;
      if (plot) begin
        nplot++;
        chk("clip_xy_visible", 32'(x >= 8'd158 && x <= 8'd159 && y >= 7'd118 && y <= 7'd119), 32'd1);
      end
      if (done == 2'b10) ndone10++;
    end
    chk("clip_plots", 32'(nplot), 32'd4);
    chk("clip_done", 32'(ndone10), 32'd1);

    // reset at the 20th plot of an 8x8 box, with req held throughout
    req = 2'b01; x0 = 8'd0; y0 = 7'd0; size0 = 4'd8; colour0 = 3'd3;
    nplot = 0; found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step();
      if (plot) nplot++;
      if (nplot == 20) found = 1;
    end
    chk("reset20_reached", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    chk("reset20_plot_busy", 32'({plot, busy, done}), 32'd0);
    reset = 1'b0;
    step();
    chk("reset20_reaccept", 32'(ack), 32'(2'b01));
    req = 2'b00;
    for (int i = 0; i < 70; i++) step();
    chk("reset20_idle", 32'(busy), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      req     = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      x0      = 8'($urandom); x1 = 8'($urandom);
      y0      = 7'($urandom); y1 = 7'($urandom);
      size0   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      size1   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      colour0 = 3'($urandom); colour1 = 3'($urandom);
      reset   = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
